// File: rtl/instr_mem_fetch.sv
// rtl/instr_mem_fetch.sv - writable instruction memory with a handshaked, wait-stated fetch port
module instr_mem_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = 32'hE1A00000,
  localparam int LAW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [ADDR_WIDTH-1:0] address,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  valid,
  output logic                  fault,
  input  logic                  load_en,
  input  logic [LAW-1:0]        load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  flush
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_IDX = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [LAW:0] DEPTH_LOAD = (LAW + 1)'(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t state, next_state;
  logic [3:0] wait_cnt;
  logic accept;
  logic [ADDR_WIDTH:0] word_index;
  logic fetch_fault;
  logic [DATA_WIDTH-1:0] fetch_word;
  logic [DATA_WIDTH-1:0] hold_word;
  logic hold_fault;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // index kept one bit wider than the address so the range check never truncates
  assign word_index  = {3'b000, address[ADDR_WIDTH-1:2]};
  assign fetch_fault = (address[1:0] != 2'b00) || (word_index >= DEPTH_IDX);
  assign fetch_word  = fetch_fault ? NOP_WORD : mem[word_index[LAW-1:0]];
  assign accept      = req & ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, RESP: begin
        if (accept) next_state = (WAIT_STATES > 0) ? WAIT : RESP;
        else        next_state = IDLE;
      end
      WAIT: begin
        if (flush)               next_state = IDLE;
        else if (wait_cnt == '0) next_state = RESP;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready = (state != WAIT);
  end

  // with no wait states the response is taken straight from the array read at acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      hold_word   <= '0;
      hold_fault  <= 1'b0;
      valid       <= 1'b0;
      fault       <= 1'b0;
      instruction <= '0;
    end else begin
      if (accept) begin
        wait_cnt   <= WAIT_LOAD;
        hold_word  <= fetch_word;
        hold_fault <= fetch_fault;
      end else if (state == WAIT && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      valid <= (next_state == RESP);
      fault <= 1'b0;
      if (next_state == RESP) begin
        instruction <= (state == WAIT) ? hold_word : fetch_word;
        fault       <= (state == WAIT) ? hold_fault : fetch_fault;
      end
    end
  end

  // array is never reset; a same-edge fetch sees the pre-write word
  always_ff @(posedge clk) begin
    if (load_en && ({1'b0, load_addr} < DEPTH_LOAD)) mem[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// tb/tb_instr_mem_fetch.sv - randomized scoreboard bench over four wait-state/depth configurations
module tb_instr_mem_fetch;

  localparam int N = 4;
  localparam logic [31:0] NOP = 32'hE1A00000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic flush = 1'b0;
  logic load_en = 1'b0;
  logic [31:0] address = '0;
  logic [9:0] load_addr = '0;
  logic [31:0] load_data = '0;
  logic [N-1:0] ready, valid, fault;
  logic [31:0] instruction [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    instr_mem_fetch #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32),
      .DEPTH(g == 2 ? 1000 : 1024),
      .WAIT_STATES(g == 0 ? 0 : g + 1),
      .NOP_WORD(NOP)
    ) dut (
      .clk(clk), .rst(rst), .req(req), .address(address),
      .ready(ready[g]), .instruction(instruction[g]), .valid(valid[g]), .fault(fault[g]),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .flush(flush)
    );
  end

  function automatic int ws(int k);
    return (k == 0) ? 0 : k + 1;
  endfunction

  function automatic int depth(int k);
    return (k == 2) ? 1000 : 1024;
  endfunction

  typedef struct {
    logic [31:0] d;
    logic        f;
    int          due;
  } exp_t;

  exp_t sb [N][$];
  logic [31:0] mm [N][1024];
  int wait_end [N];
  logic [31:0] last [N];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: one sample per cycle, just after the active edge
  initial forever begin
    @(posedge clk);
    #1;
    if (mon_en && !rst) begin
      for (int k = 0; k < N; k++) begin
        chk($sformatf("ready[%0d]", k), 32'(ready[k]), 32'(cyc >= wait_end[k]));
        if (valid[k] === 1'b1) begin
          if (sb[k].size() == 0 || sb[k][0].due != cyc) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid[%0d]: got valid=1 expected valid=0 (cycle %0d)", k, cyc);
          end else begin
            e = sb[k].pop_front();
            chk($sformatf("instr[%0d]", k), instruction[k], e.d);
            chk($sformatf("fault[%0d]", k), 32'(fault[k]), 32'(e.f));
            last[k] = e.d;
          end
        end else begin
          if (sb[k].size() > 0 && sb[k][0].due <= cyc) begin
            tests++;
            fails++;
            $display("FAIL missing_valid[%0d]: got valid=%b expected valid=1 (cycle %0d)", k, valid[k], cyc);
            void'(sb[k].pop_front());
          end
          chk($sformatf("idle_fault[%0d]", k), 32'(fault[k]), 32'(1'b0));
          chk($sformatf("hold_instr[%0d]", k), instruction[k], last[k]);
        end
      end
    end
  end

  task automatic step(input logic r, input logic [31:0] a, input logic fl,
                      input logic le, input logic [9:0] la, input logic [31:0] ld);
    int u;
    @(negedge clk);
    req = r; address = a; flush = fl;
    load_en = le; load_addr = la; load_data = ld;
    u = cyc + 1;
    for (int k = 0; k < N; k++) begin
      bit rdy;
      logic [31:0] idx;
      logic f;
      rdy = (cyc >= wait_end[k]);
      idx = a >> 2;
      f = (a[1:0] != 2'b00) || (idx >= 32'(depth(k)));
      if (r && rdy && !fl) begin
        sb[k].push_back('{d: (f ? NOP : mm[k][idx[9:0]]), f: f, due: u + ws(k)});
        wait_end[k] = u + ws(k);
      end else if (!rdy && fl) begin
        if (sb[k].size() > 0) void'(sb[k].pop_back());
        wait_end[k] = u;
      end
    end
    if (le) begin
      for (int k = 0; k < N; k++)
        if (int'(la) < depth(k)) mm[k][la] = ld;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rst_valid[%0d]", k), 32'(valid[k]), 32'(1'b0));
      chk($sformatf("rst_fault[%0d]", k), 32'(fault[k]), 32'(1'b0));
      chk($sformatf("rst_instr[%0d]", k), instruction[k], 32'h0);
      chk($sformatf("rst_ready[%0d]", k), 32'(ready[k]), 32'(1'b1));
    end
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      sb[k].delete();
      wait_end[k] = 0;
      last[k] = '0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] fault_addrs [7];
    for (int k = 0; k < N; k++) begin
      wait_end[k] = 0;
      last[k] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 1024; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 10'(i), $urandom);

    // back-to-back fetches of freshly loaded program words
    step(1'b0, 32'h0, 1'b0, 1'b1, 10'd0, 32'hE3A01A01);
    step(1'b0, 32'h0, 1'b0, 1'b1, 10'd1, 32'hE3A00014);
    step(1'b0, 32'h0, 1'b0, 1'b1, 10'd2, 32'hE3A02103);
    step(1'b1, 32'd0, 1'b0, 1'b0, 10'd0, 32'h0);
    step(1'b1, 32'd4, 1'b0, 1'b0, 10'd0, 32'h0);
    step(1'b1, 32'd8, 1'b0, 1'b0, 10'd0, 32'h0);
    idle(6);

    // request held continuously: acceptance in each response cycle
    for (int i = 0; i < 12; i++) step(1'b1, 32'(4 * (i % 3)), 1'b0, 1'b0, 10'd0, 32'h0);
    idle(6);

    fault_addrs = '{32'h6, 32'd4096, 32'd4092, 32'd4000, 32'd3996, 32'h3, 32'hFFFFFFFC};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, fault_addrs[i], 1'b0, 1'b0, 10'd0, 32'h0);
      idle(6);
    end

    // load and fetch of the same word on the same edge
    step(1'b1, 32'd20, 1'b0, 1'b1, 10'd5, 32'hE0823002);
    idle(6);
    step(1'b1, 32'd20, 1'b0, 1'b0, 10'd0, 32'h0);
    idle(6);

    // flush in the second wait cycle, with req held alongside
    step(1'b1, 32'd40, 1'b0, 1'b0, 10'd0, 32'h0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 32'h0);
    step(1'b1, 32'd44, 1'b1, 1'b0, 10'd0, 32'h0);
    step(1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 32'h0);
    idle(6);

    // asynchronous reset with a response on one instance and a fetch in flight on others
    step(1'b1, 32'd4, 1'b0, 1'b0, 10'd0, 32'h0);
    step(1'b1, 32'd8, 1'b0, 1'b0, 10'd0, 32'h0);
    pulse_reset();
    step(1'b1, 32'd4, 1'b0, 1'b0, 10'd0, 32'h0);
    idle(6);
    step(1'b1, 32'd20, 1'b0, 1'b0, 10'd0, 32'h0);
    idle(6);

    repeat (4000) begin
      logic [31:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 8)      a = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      else if (sel < 9) a = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
      else              a = $urandom;
      step($urandom_range(0, 9) < 7, a, $urandom_range(0, 19) == 0,
           $urandom_range(0, 4) == 0, 10'($urandom_range(0, 1023)), $urandom);
      if ($urandom_range(0, 499) == 0) pulse_reset();
    end

    idle(10);
    for (int k = 0; k < N; k++)
      chk($sformatf("drained[%0d]", k), 32'(sb[k].size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
